// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined RV32M multiplier.
// Operand signedness per op is decided here so the top and the bench agree on one definition.
package mult_pkg;

  localparam int MULT_OP_W = 2;

  typedef enum logic [MULT_OP_W-1:0] {
    MULT_MUL    = 2'd0,
    MULT_MULH   = 2'd1,
    MULT_MULHSU = 2'd2,
    MULT_MULHU  = 2'd3
  } mult_op_e;

  function automatic logic mult_is_signed_a(mult_op_e op);
    return op != MULT_MULHU;
  endfunction

  function automatic logic mult_is_signed_b(mult_op_e op);
    return (op == MULT_MUL) || (op == MULT_MULH);
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Issue-side and CDB-side handshake bundle of the multiplier unit.
// The master drives operations and the CDB grant; the slave is the multiplier itself.
interface mult_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  import mult_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mult_op_e         in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/mult_pipe_stage.sv
// One chunk step of the shift-and-add multiplier: adds the low S bits of the
// multiplier times the shifted multiplicand, then shifts both for the next stage.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int S     = 16,
  parameter int TAG_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              advance,
  input  logic              src_valid,
  input  mult_op_e          src_op,
  input  logic [TAG_W-1:0]  src_tag,
  input  logic [2*XLEN-1:0] src_product,
  input  logic [2*XLEN-1:0] src_mplier,
  input  logic [2*XLEN-1:0] src_mcand,
  output logic              valid,
  output mult_op_e          op,
  output logic [TAG_W-1:0]  tag,
  output logic [2*XLEN-1:0] product,
  output logic [2*XLEN-1:0] mplier,
  output logic [2*XLEN-1:0] mcand
);

  localparam int            W          = 2 * XLEN;
  localparam logic [W-1:0]  CHUNK_MASK = {W{1'b1}} >> (W - S);

  logic [W-1:0] partial;

  assign partial = (src_mplier & CHUNK_MASK) * src_mcand;

  // Flush only kills the valid bit; data may go stale because nobody reads it without valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid   <= 1'b0;
      op      <= MULT_MUL;
      tag     <= '0;
      product <= '0;
      mplier  <= '0;
      mcand   <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (advance) begin
        valid <= src_valid;
      end
      if (advance) begin
        op      <= src_op;
        tag     <= src_tag;
        product <= src_product + partial;
        mplier  <= src_mplier >> S;
        mcand   <= src_mcand << S;
      end
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32M multiplier functional unit (MUL/MULH/MULHSU/MULHU) with a
// global stall, tag transport and mispredict flush; latency equals NUM_STAGE.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 4,
  parameter int TAG_W     = 6
) (
  input  logic       clock,
  input  logic       reset,
  mult_pipe_if.slave bus
);

  localparam int W = 2 * XLEN;
  localparam int S = W / NUM_STAGE;

  generate
    if ((NUM_STAGE < 1) || ((W % NUM_STAGE) != 0)) begin : g_bad_depth
      $error("mult_pipe: NUM_STAGE=%0d does not divide 2*XLEN=%0d", NUM_STAGE, W);
    end
  endgenerate

  // Index 0 is the formatted input; index k is the output register of stage k.
  logic             stage_valid   [0:NUM_STAGE];
  mult_op_e         stage_op      [0:NUM_STAGE];
  logic [TAG_W-1:0] stage_tag     [0:NUM_STAGE];
  logic [W-1:0]     stage_product [0:NUM_STAGE];
  logic [W-1:0]     stage_mplier  [0:NUM_STAGE];
  logic [W-1:0]     stage_mcand   [0:NUM_STAGE];

  logic valid_last;
  logic advance;

  assign valid_last    = stage_valid[NUM_STAGE];
  assign advance       = ~valid_last | bus.out_ready;
  assign bus.in_ready  = advance & ~bus.flush & ~reset;
  assign bus.out_valid = valid_last & ~bus.flush;

  assign stage_valid[0]   = bus.in_valid & bus.in_ready;
  assign stage_op[0]      = bus.in_op;
  assign stage_tag[0]     = bus.in_tag;
  assign stage_product[0] = '0;
  assign stage_mcand[0]   = mult_is_signed_a(bus.in_op) ? {{XLEN{bus.in_a[XLEN-1]}}, bus.in_a}
                                                        : {{XLEN{1'b0}}, bus.in_a};
  assign stage_mplier[0]  = mult_is_signed_b(bus.in_op) ? {{XLEN{bus.in_b[XLEN-1]}}, bus.in_b}
                                                        : {{XLEN{1'b0}}, bus.in_b};

  generate
    for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_stage
      mult_pipe_stage #(
        .XLEN  (XLEN),
        .S     (S),
        .TAG_W (TAG_W)
      ) u_stage (
        .clock       (clock),
        .reset       (reset),
        .flush       (bus.flush),
        .advance     (advance),
        .src_valid   (stage_valid[k-1]),
        .src_op      (stage_op[k-1]),
        .src_tag     (stage_tag[k-1]),
        .src_product (stage_product[k-1]),
        .src_mplier  (stage_mplier[k-1]),
        .src_mcand   (stage_mcand[k-1]),
        .valid       (stage_valid[k]),
        .op          (stage_op[k]),
        .tag         (stage_tag[k]),
        .product     (stage_product[k]),
        .mplier      (stage_mplier[k]),
        .mcand       (stage_mcand[k])
      );
    end
  endgenerate

  // Result select reads only the last stage register, so there is no path from in_* to out_*.
  always_comb begin
    bus.out_result = stage_product[NUM_STAGE][W-1:XLEN];
    if (stage_op[NUM_STAGE] == MULT_MUL) begin
      bus.out_result = stage_product[NUM_STAGE][XLEN-1:0];
    end
  end

  assign bus.out_tag = stage_tag[NUM_STAGE];

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: a queue-based reference model scores every
// output transfer, and directed scenarios pin latency, stall, flush and reset behaviour.
module tb_mult_pipe;
  import mult_pkg::*;

  localparam int XLEN      = 32;
  localparam int NUM_STAGE = 4;
  localparam int TAG_W     = 6;

  typedef struct {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  exp_t             expq        [$];
  logic [XLEN-1:0]  got_results [$];
  logic [TAG_W-1:0] got_tags    [$];
  int               transfers  = 0;
  int               compared   = 0;
  int               mismatched = 0;

  mult_op_e        t2_op  [6] = '{MULT_MUL, MULT_MULH, MULT_MULHSU, MULT_MULHU, MULT_MULH, MULT_MULHU};
  logic [XLEN-1:0] t2_a   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h80000000};
  logic [XLEN-1:0] t2_b   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h00000002};
  logic [XLEN-1:0] t2_exp [6] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                  32'h40000000, 32'h00000001};

  always #5 clock = ~clock;

  mult_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mult_pipe #(
    .XLEN      (XLEN),
    .NUM_STAGE (NUM_STAGE),
    .TAG_W     (TAG_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: full-width product from sign/zero extended 64-bit operands, then pick a half.
  function automatic logic [XLEN-1:0] refResult(mult_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MULT_MUL:    begin p = sa * sb; return p[31:0];  end
      MULT_MULH:   begin p = sa * sb; return p[63:32]; end
      MULT_MULHSU: begin p = sa * ub; return p[63:32]; end
      default:     begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input mult_op_e op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    bus.in_valid = valid;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  // Holds the op until the unit takes it; returns just after the accepting edge.
  task automatic sendOne(input mult_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    logic acc;
    acc = 1'b0;
    applyStimulus(1'b1, op, a, b, tag);
    for (int w = 0; w < 30 && !acc; w++) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) checkOutput("accept timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && expq.size() != 0; i++) step();
    checkOutput({name, " drained"}, 64'(expq.size()), 64'd0);
  endtask

  // Compare process: scores each output transfer, then advances the model for this edge.
  always @(negedge clock) begin
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      transfers++;
      got_results.push_back(bus.out_result);
      got_tags.push_back(bus.out_tag);
      if (expq.size() == 0) begin
        checkOutput("unexpected out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("out_result", {32'd0, bus.out_result}, {32'd0, e.result});
        checkOutput("out_tag", {58'd0, bus.out_tag}, {58'd0, e.tag});
      end
    end
    if (bus.flush === 1'b1) begin
      checkOutput("out_valid under flush", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("in_ready under flush", {63'd0, bus.in_ready}, 64'd0);
    end
    if (reset === 1'b1) checkOutput("in_ready under reset", {63'd0, bus.in_ready}, 64'd0);
    if (reset === 1'b1 || bus.flush === 1'b1) begin
      expq.delete();
    end else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      e.result = refResult(bus.in_op, bus.in_a, bus.in_b);
      e.tag    = bus.in_tag;
      expq.push_back(e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);

    // Reset state
    step();
    step();
    checkOutput("reset in_ready", {63'd0, bus.in_ready}, 64'd0);
    checkOutput("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset out_result", {32'd0, bus.out_result}, 64'd0);
    checkOutput("reset out_tag", {58'd0, bus.out_tag}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post-reset in_ready", {63'd0, bus.in_ready}, 64'd1);

    // T1: latency of a single MUL
    sendOne(MULT_MUL, 32'd7, 32'd6, 6'd5);
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    checkOutput("T1 out_valid e0", {63'd0, bus.out_valid}, 64'd0);
    step();
    checkOutput("T1 out_valid e1", {63'd0, bus.out_valid}, 64'd0);
    step();
    checkOutput("T1 out_valid e2", {63'd0, bus.out_valid}, 64'd0);
    step();
    checkOutput("T1 out_valid e3", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("T1 out_result", {32'd0, bus.out_result}, 64'd42);
    checkOutput("T1 out_tag", {58'd0, bus.out_tag}, 64'd5);
    step();
    checkOutput("T1 out_valid e4", {63'd0, bus.out_valid}, 64'd0);

    // T2: operand extremes, back to back, against literal answers
    base = got_results.size();
    for (int i = 0; i < 6; i++) sendOne(t2_op[i], t2_a[i], t2_b[i], 6'(i + 20));
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    waitDrain("T2");
    checkOutput("T2 count", 64'(got_results.size() - base), 64'd6);
    if (got_results.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("T2 literal %0d", i), {32'd0, got_results[base+i]}, {32'd0, t2_exp[i]});
      end
    end

    // T3: 8 ops with a 3-cycle CDB stall mid-stream
    base = transfers;
    fork
      begin
        for (int t = 0; t < 8; t++) sendOne(MULT_MUL, $urandom, $urandom, 6'(t));
        applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
      end
      begin
        repeat (5) step();
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          checkOutput("T3 in_ready stalled", {63'd0, bus.in_ready}, 64'd0);
          @(posedge clock);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    waitDrain("T3");
    checkOutput("T3 transfers", 64'(transfers - base), 64'd8);
    if (transfers - base == 8) begin
      for (int t = 0; t < 8; t++) begin
        checkOutput($sformatf("T3 tag order %0d", t), {58'd0, got_tags[base+t]}, 64'(t));
      end
    end

    // T4: flush kills 3 in-flight ops; next op still has full latency
    base = transfers;
    for (int i = 0; i < 3; i++) sendOne(MULT_MUL, 32'(i + 2), 32'd100, 6'(i + 40));
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checkOutput("T4 killed e3", {63'd0, bus.out_valid}, 64'd0);
    sendOne(MULT_MUL, 32'd3, 32'd3, 6'd9);
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("T4 quiet %0d", i), {63'd0, bus.out_valid}, 64'd0);
      step();
    end
    checkOutput("T4 out_valid", {63'd0, bus.out_valid}, 64'd1);
    checkOutput("T4 out_result", {32'd0, bus.out_result}, 64'd9);
    checkOutput("T4 out_tag", {58'd0, bus.out_tag}, 64'd9);
    step();
    checkOutput("T4 transfers", 64'(transfers - base), 64'd1);

    // T5: reset with 4 ops in flight and the CDB stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendOne(MULT_MUL, 32'(i + 5), 32'd7, 6'(i + 11));
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    reset = 1'b1;
    step();
    checkOutput("T5 out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("T5 out_result", {32'd0, bus.out_result}, 64'd0);
    checkOutput("T5 out_tag", {58'd0, bus.out_tag}, 64'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    base = transfers;
    repeat (10) step();
    checkOutput("T5 no stale result", 64'(transfers - base), 64'd0);

    // Randomized traffic with back-pressure and occasional flushes
    for (int c = 0; c < 400; c++) begin
      logic [XLEN-1:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 7);
      ra = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'd0 : $urandom;
      sel = $urandom_range(0, 7);
      rb = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'd0 : $urandom;
      applyStimulus($urandom_range(0, 9) < 7, mult_op_e'(2'($urandom_range(0, 3))), ra, rb,
                    6'($urandom_range(0, 63)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    applyStimulus(1'b0, MULT_MUL, '0, '0, '0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    waitDrain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
